// File: rtl/atm_pkg.sv
// Shared types for the ATM access-code sender: state and result encodings,
// digit width and the code validity rule.
package atm_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREAMBLE  = 3'd1,
    ST_DIGIT1    = 3'd2,
    ST_DIGIT2    = 3'd3,
    ST_DIGIT3    = 3'd4,
    ST_WAIT_RESP = 3'd5,
    ST_FINISH    = 3'd6
  } sender_state_t;

  typedef enum logic [1:0] {
    RES_NONE      = 2'b00,
    RES_PAID      = 2'b01,
    RES_DESTROYED = 2'b10,
    RES_FAILED    = 2'b11
  } result_t;

  // The ATM detects digits by value change, so a digit equal to its
  // predecessor (the preamble counts as 0) can never be received.
  function automatic logic code_sendable(input logic [CODE_W-1:0] c1,
                                         input logic [CODE_W-1:0] c2,
                                         input logic [CODE_W-1:0] c3);
    return (c1 != '0) && (c2 != c1) && (c3 != c2);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable saturating down-counter; zero_o flags that the loaded interval
// has elapsed.
module cycle_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/atm_code_sender.sv
// Card-side transmitter: sends preamble plus three digits to the ATM, waits
// for the outcome and retries silent rejections up to MAX_TRIES times.
module atm_code_sender
  import atm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 8,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code1,
  input  logic [CODE_W-1:0] code2,
  input  logic [CODE_W-1:0] code3,
  input  logic              dinheiro,
  input  logic              destroi,
  output logic              cartao,
  output logic [CODE_W-1:0] cod,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic [1:0]        attempts,
  output logic [2:0]        state_o
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT - 1);
  localparam logic [1:0]        TRY_LIMIT = 2'(MAX_TRIES);

  sender_state_t     state_q, state_d;
  result_t           result_q, result_d;
  logic [1:0]        attempts_q, attempts_d;
  logic [CODE_W-1:0] dig1_q, dig1_d;
  logic [CODE_W-1:0] dig2_q, dig2_d;
  logic [CODE_W-1:0] dig3_q, dig3_d;

  logic              hold_load, hold_zero;
  logic              to_load, to_en, to_zero;
  logic [HOLD_W-1:0] hold_val;
  logic [TO_W-1:0]   to_val;
  logic              unused_counts;

  // Hold reloads on any state change (including a retry back to PREAMBLE);
  // timeout reloads only on WAIT_RESP entry.
  assign hold_load = (state_d != state_q);
  assign to_load   = (state_d == ST_WAIT_RESP) && (state_q != ST_WAIT_RESP);
  assign to_en     = (state_q == ST_WAIT_RESP);

  cycle_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk_i        (clk_2),
    .reset_i      (reset),
    .load_i       (hold_load),
    .load_value_i (HOLD_LOAD),
    .en_i         (1'b1),
    .value_o      (hold_val),
    .zero_o       (hold_zero)
  );

  cycle_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk_i        (clk_2),
    .reset_i      (reset),
    .load_i       (to_load),
    .load_value_i (TO_LOAD),
    .en_i         (to_en),
    .value_o      (to_val),
    .zero_o       (to_zero)
  );

  assign unused_counts = ^{hold_val, to_val};

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= RES_NONE;
      attempts_q <= '0;
      dig1_q     <= '0;
      dig2_q     <= '0;
      dig3_q     <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      attempts_q <= attempts_d;
      dig1_q     <= dig1_d;
      dig2_q     <= dig2_d;
      dig3_q     <= dig3_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    attempts_d = attempts_q;
    dig1_d     = dig1_q;
    dig2_d     = dig2_q;
    dig3_d     = dig3_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dig1_d = code1;
          dig2_d = code2;
          dig3_d = code3;
          if (code_sendable(code1, code2, code3)) begin
            state_d    = ST_PREAMBLE;
            result_d   = RES_NONE;
            attempts_d = 2'd1;
          end else begin
            state_d    = ST_FINISH;
            result_d   = RES_FAILED;
            attempts_d = '0;
          end
        end
      end
      ST_PREAMBLE: if (hold_zero) state_d = ST_DIGIT1;
      ST_DIGIT1:   if (hold_zero) state_d = ST_DIGIT2;
      ST_DIGIT2:   if (hold_zero) state_d = ST_DIGIT3;
      ST_DIGIT3:   if (hold_zero) state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (destroi) begin
          state_d  = ST_FINISH;
          result_d = RES_DESTROYED;
        end else if (dinheiro) begin
          state_d  = ST_FINISH;
          result_d = RES_PAID;
        end else if (to_zero) begin
          if (attempts_q < TRY_LIMIT) begin
            state_d    = ST_PREAMBLE;
            attempts_d = attempts_q + 2'd1;
          end else begin
            state_d  = ST_FINISH;
            result_d = RES_FAILED;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cartao = 1'b0;
    cod    = '0;
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_FINISH);
    unique case (state_q)
      ST_PREAMBLE:  cartao = 1'b1;
      ST_DIGIT1:    begin cartao = 1'b1; cod = dig1_q; end
      ST_DIGIT2:    begin cartao = 1'b1; cod = dig2_q; end
      ST_DIGIT3:    begin cartao = 1'b1; cod = dig3_q; end
      ST_WAIT_RESP: begin cartao = 1'b1; cod = dig3_q; end
      default:      begin cartao = 1'b0; cod = '0; end
    endcase
  end

  assign result   = result_q;
  assign attempts = attempts_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_atm_code_sender.sv
// Directed bench for atm_code_sender with a scripted ATM responder.
module tb_atm_code_sender;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] code1, code2, code3;
  logic       dinheiro, destroi;
  logic       cartao;
  logic [2:0] cod;
  logic       busy, done;
  logic [1:0] result, attempts;
  logic [2:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  atm_code_sender #(.HOLD_CYCLES(1), .TIMEOUT(8), .MAX_TRIES(3)) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .start    (start),
    .code1    (code1),
    .code2    (code2),
    .code3    (code3),
    .dinheiro (dinheiro),
    .destroi  (destroi),
    .cartao   (cartao),
    .cod      (cod),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .attempts (attempts),
    .state_o  (state_o)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_2);
    #1;
  endtask

  task automatic launch(input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] c3);
    code1 = c1;
    code2 = c2;
    code3 = c3;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Code 1,3,6 rejected each attempt; optionally the ATM destroys on the last.
  task automatic run_retry(input bit destroy_last);
    launch(3'd1, 3'd3, 3'd6);
    for (int a = 1; a <= 3; a++) begin
      check("retry_pre_state", state_o, 1);
      check("retry_pre_cod", cod, 0);
      check("retry_attempts", attempts, a);
      repeat (4) tick();
      check("retry_wait_state", state_o, 5);
      check("retry_wait_cod", cod, 6);
      if (destroy_last && a == 3) begin
        destroi = 1'b1;
        tick();
      end else begin
        repeat (7) tick();
        check("retry_wait_last", state_o, 5);
        tick();
      end
    end
    check("retry_fin_state", state_o, 6);
    check("retry_fin_done", done, 1);
    check("retry_fin_result", result, destroy_last ? 2 : 3);
    check("retry_fin_attempts", attempts, 3);
    check("retry_fin_cartao", cartao, 0);
    destroi = 1'b0;
    tick();
    check("retry_idle", state_o, 0);
  endtask

  task automatic run_unsendable(input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] c3);
    launch(c1, c2, c3);
    check("bad_state", state_o, 6);
    check("bad_cartao", cartao, 0);
    check("bad_done", done, 1);
    check("bad_result", result, 3);
    check("bad_attempts", attempts, 0);
    tick();
    check("bad_idle", state_o, 0);
    check("bad_cartao2", cartao, 0);
    check("bad_done2", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dinheiro = 1'b0; destroi = 1'b0;
    code1 = '0; code2 = '0; code3 = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_state", state_o, 0);
    check("rst_cartao", cartao, 0);
    check("rst_cod", cod, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_attempts", attempts, 0);

    // Paid on first attempt; start re-pulsed while busy must be ignored.
    code1 = 3'd1; code2 = 3'd3; code3 = 3'd7; start = 1'b1;
    tick();
    check("paid_c1_state", state_o, 1);
    check("paid_c1_cod", cod, 0);
    check("paid_c1_cartao", cartao, 1);
    check("paid_c1_busy", busy, 1);
    code1 = 3'd5;
    tick();
    start = 1'b0;
    check("paid_c2_state", state_o, 2);
    check("paid_c2_cod", cod, 1);
    tick();
    check("paid_c3_cod", cod, 3);
    tick();
    check("paid_c4_cod", cod, 7);
    tick();
    check("paid_c5_state", state_o, 5);
    check("paid_c5_cod", cod, 7);
    tick();
    tick();
    dinheiro = 1'b1;
    check("paid_c7_state", state_o, 5);
    tick();
    check("paid_c8_state", state_o, 6);
    check("paid_c8_done", done, 1);
    check("paid_c8_result", result, 1);
    check("paid_c8_attempts", attempts, 1);
    check("paid_c8_cartao", cartao, 0);
    check("paid_c8_cod", cod, 0);
    tick();
    dinheiro = 1'b0;
    check("paid_c9_state", state_o, 0);
    check("paid_c9_done", done, 0);
    check("paid_c9_result", result, 1);
    check("paid_c9_busy", busy, 0);

    run_retry(1'b1);
    run_retry(1'b0);

    run_unsendable(3'd3, 3'd3, 3'd7);
    run_unsendable(3'd0, 3'd3, 3'd7);
    run_unsendable(3'd1, 3'd3, 3'd3);

    // Both responses at once: destruction wins.
    launch(3'd2, 3'd5, 3'd1);
    repeat (4) tick();
    check("both_wait", state_o, 5);
    dinheiro = 1'b1;
    destroi  = 1'b1;
    tick();
    check("both_state", state_o, 6);
    check("both_result", result, 2);
    dinheiro = 1'b0;
    destroi  = 1'b0;
    tick();

    // Reset in DIGIT2 aborts without a done pulse.
    launch(3'd4, 3'd2, 3'd6);
    tick(); tick();
    check("abort_digit2", state_o, 3);
    check("abort_digit2_cod", cod, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", state_o, 0);
    check("abort_done", done, 0);
    check("abort_cartao", cartao, 0);
    check("abort_cod", cod, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_attempts", attempts, 0);
    tick();
    check("abort_done2", done, 0);
    check("abort_idle2", state_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_code_sender.md
# atm_code_sender

Card-side transmitter for the ATM access-code protocol. On a `start` pulse it:
- asserts `cartao`;
- sends a zero preamble, then three code digits on `cod`, each held a fixed number of cycles;
- watches the ATM's `dinheiro`/`destroi` lines for the outcome.

A silent rejection (timeout) triggers an automatic retry, up to a limit. The block sits between the switch inputs and the ATM FSM, on the other end of the `cartao`/`cod` interface. It is used both as a self-test driver on the board and as a bench stimulus generator.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: cycles each symbol (preamble, each digit) is held on `cod`; must be ≥1.
- `TIMEOUT`, default 8: cycles spent in WAIT_RESP with no response before an attempt counts as failed.
- `MAX_TRIES`, default 3: attempts before giving up.

Ports:
- `clk_2` in 1: single clock.
- `reset` in 1: synchronous, active-high; sampled only on the `clk_2` rising edge.
- `start` in 1: request to transmit; sampled only in IDLE.
- `code1`, `code2`, `code3` in 3 each: digits to send; latched on accepted `start`.
- `dinheiro` in 1: ATM money-out indication (sticky on the ATM side).
- `destroi` in 1: ATM card-destroyed indication.
- `cartao` out 1: card inserted.
- `cod` out 3: symbol driven to the ATM.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse when the transaction ends.
- `result` out 2: 00 NONE, 01 PAID, 10 DESTROYED, 11 FAILED. Held until the next accepted `start`.
- `attempts` out 2: attempts started in the current or last transaction.
- `state_o` out 3: current state, for the 7-segment display.

## Operation
- States: IDLE, PREAMBLE, DIGIT1, DIGIT2, DIGIT3, WAIT_RESP, FINISH.
- Reset:
  - state IDLE;
  - `cartao`=0, `cod`=0, `busy`=0, `done`=0, `result`=NONE, `attempts`=0;
  - latched digits cleared.
- IDLE with `start`=1:
  - latch `code1..3`;
  - validate: the code is unsendable if `code1`==0, `code2`==`code1`, or `code3`==`code2`, because the ATM detects digits by value change.
  - Unsendable: go to FINISH with `result`=FAILED and `attempts`=0; `cartao` is never asserted.
  - Sendable: go to PREAMBLE with `attempts`=1 and `result`=NONE.
- PREAMBLE: `cartao`=1, `cod`=0 for HOLD_CYCLES, then DIGIT1.
- DIGITn: `cod`=latched digit n for HOLD_CYCLES, then the next state. DIGIT3 goes to WAIT_RESP.
- WAIT_RESP:
  - `cod` stays at digit 3 so the ATM cannot re-arm on 0.
  - `destroi`=1 → FINISH, `result`=DESTROYED. This has priority when `destroi` and `dinheiro` are both high.
  - `dinheiro`=1 → FINISH, `result`=PAID.
  - After TIMEOUT cycles with neither: if `attempts`<MAX_TRIES, increment `attempts` and go to PREAMBLE; otherwise FINISH with `result`=FAILED.
- FINISH:
  - `done`=1 for one cycle;
  - `cartao`=0, `cod`=0;
  - next state IDLE.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE is ignored.
- Reset mid-transaction aborts immediately; no `done` pulse.
- The hold counter reloads on every state entry. The timeout counter reloads on WAIT_RESP entry.
- Counters never wrap: the hold counter width is clog2(HOLD_CYCLES)+1 and the timeout counter width is clog2(TIMEOUT)+1.

## Timing
- Registered (Moore) outputs, with state-derived `cod`/`cartao`.
- With HOLD_CYCLES=1 and `start` high in cycle 0:
  - cycle 1: PREAMBLE (`cod`=0);
  - cycles 2, 3, 4: digits 1, 2, 3;
  - cycle 5: WAIT_RESP begins.
- Against the ATM FSM, a correct code raises `dinheiro` visible in cycle 7. The default TIMEOUT=8 therefore covers the response path.
- General latency, `start` to first WAIT_RESP cycle: 1 + 4·HOLD_CYCLES cycles.
- A retry re-enters PREAMBLE on the cycle after the timeout expires.
- `done` is asserted in the FINISH cycle. `result`/`attempts` are valid from that cycle on.

## Structure
- Shared package `atm_pkg` holds:
  - `sender_state_t` enum (3-bit, encodings 0–6 in the listed order);
  - `result_t` enum;
  - `CODE_W`=3.
- One sub-module, `cycle_counter`: loadable down-counter with `load`, `value`, `zero` outputs. It is instantiated twice, for hold and for timeout.

## Test plan
- Code 1,3,7 with the ATM FSM as responder, HOLD=1 → `cod` sequence 0,1,3,7 in cycles 1–4; `result`=PAID, `attempts`=1, `done` in cycle 8.
- Code 1,3,6 against the ATM FSM, MAX_TRIES=3 → three full attempts, each preceded by a `cod`=0 preamble; the ATM raises `destroi` after the third rejection; `result`=DESTROYED, `attempts`=3.
- Code 1,3,6 with the responder tied off (`dinheiro`=`destroi`=0) → 3 attempts, each timing out after 8 cycles; `result`=FAILED.
- Code 3,3,7 or 0,3,7 → FINISH next cycle, `cartao` never 1, `result`=FAILED, `attempts`=0.
- `dinheiro` and `destroi` forced high together in WAIT_RESP → `result`=DESTROYED.
- `reset` asserted in DIGIT2 → next cycle IDLE with all outputs at reset values and no `done` pulse. `start` pulsed while `busy` → ignored.
